// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: one full-adder cell with a registered carry processes the
// two operands LSB-first, one bit per clock. The WIDTH-bit sum and the
// carry-out are published together once every bit has been processed.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst_n  : synchronous active-low reset
//   start  : begin an addition (accepted only in IDLE or DONE)
//   a, b   : WIDTH-bit operands, captured on the accepting edge
//   cin    : carry-in, captured on the accepting edge
//   busy   : high while bits are being processed
//   done   : one-cycle pulse, sum/cout have just been updated
//   sum    : registered result, held until the next result
//   cout   : registered final carry, held until the next result
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Counter must hold WIDTH without wrapping.
    localparam int unsigned       CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q,   state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] res_q,     res_d;
    logic             carry_q,   carry_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [WIDTH-1:0] sum_q,     sum_d;
    logic             cout_q,    cout_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;

    // Full-adder cell on the current LSBs and the stored carry.
    logic             bit_s_c;
    logic             bit_c_c;
    logic [WIDTH-1:0] res_shift_c;

    always_comb begin
        bit_s_c = shift_a_q[0] ^ shift_b_q[0] ^ carry_q;
        bit_c_c = (shift_a_q[0] & shift_b_q[0])
                | (shift_a_q[0] & carry_q)
                | (shift_b_q[0] & carry_q);
    end

    // Result register fills from the MSB end so the LSB ends up at bit 0.
    always_comb begin
        res_shift_c            = res_q >> 1;
        res_shift_c[WIDTH-1]   = bit_s_c;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        res_d     = res_q;
        carry_d   = carry_q;
        count_d   = count_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    shift_a_d = a;
                    shift_b_d = b;
                    carry_d   = cin;
                    res_d     = '0;
                    count_d   = '0;
                    busy_d    = 1'b1;
                    state_d   = S_SHIFT;
                end else begin
                    state_d   = S_IDLE;
                end
            end

            S_SHIFT: begin
                shift_a_d = shift_a_q >> 1;
                shift_b_d = shift_b_q >> 1;
                carry_d   = bit_c_c;
                res_d     = res_shift_c;
                count_d   = count_q + CNT_W'(1);
                busy_d    = 1'b1;
                // Last bit: publish the complete result and carry together.
                if (count_q == LAST_BIT) begin
                    sum_d   = res_shift_c;
                    cout_d  = bit_c_c;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            res_q     <= '0;
            carry_q   <= 1'b0;
            count_q   <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
            count_q   <= count_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Scoreboard bench for serial_adder: stimulus pushes the expected {cout,sum}
// into a queue, a negedge monitor pops and compares on every done pulse.
// A second WIDTH=1 instance covers the single-bit corner.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1, b1;
    logic       cin1;
    logic       busy1, done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_vec  = 0;
    int n_miss = 0;
    int done_cnt = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            done_cnt++;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL sb_unexpected_done: got %0h expected none", {cout, sum});
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({cout, sum} !== e) begin
                    n_miss++;
                    $display("FAIL sb_result: got %0h expected %0h", {cout, sum}, e);
                end
            end
        end
    end

    // Issue one operation, then check latency and busy length.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc);
        int lat;
        int bcnt;
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        exp_q.push_back(9'(ta) + 9'(tb_v) + 9'(tc));
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
        end while (!done && lat < 40);
        check("latency", 64'(lat), 64'd9);
        check("busy_cycles", 64'(bcnt), 64'd8);
        @(posedge clk); #1;
    endtask

    task automatic wait_done(output int wd);
        wd = 0;
        do begin
            @(negedge clk);
            wd++;
        end while (!done && wd < 40);
    endtask

    logic [7:0] bb_a[4]   = '{8'h01, 8'h80, 8'h7F, 8'hC3};
    logic [7:0] bb_b[4]   = '{8'h02, 8'h80, 8'h01, 8'h3C};
    logic       bb_c[4]   = '{1'b0,  1'b1,  1'b0,  1'b1};

    initial begin
        int wd;
        int d0;
        int lat;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sum",  64'(sum),  64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        run_op(8'h00, 8'h00, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1);
        run_op(8'h3C, 8'h0F, 1'b0);
        check("hold_sum",  64'(sum),  64'h4B);
        check("hold_cout", 64'(cout), 64'd0);

        // start and operand changes during SHIFT are ignored.
        d0 = done_cnt;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h046);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; a = 8'h11; b = 8'h22;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = ~a; b = ~b; cin = ~cin;
            @(posedge clk); #1;
        end
        repeat (20) @(posedge clk);
        #1;
        check("shift_start_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("shift_start_sum", 64'(sum), 64'h46);

        // Back-to-back with start held high.
        a = bb_a[0]; b = bb_b[0]; cin = bb_c[0]; start = 1'b1;
        exp_q.push_back(9'(bb_a[0]) + 9'(bb_b[0]) + 9'(bb_c[0]));
        @(posedge clk); #1;
        for (int i = 1; i < 4; i++) begin
            a = bb_a[i]; b = bb_b[i]; cin = bb_c[i];
            exp_q.push_back(9'(bb_a[i]) + 9'(bb_b[i]) + 9'(bb_c[i]));
            wait_done(wd);
            check("b2b_interval", 64'(wd), 64'd9);
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done(wd);
        check("b2b_interval_last", 64'(wd), 64'd9);
        @(posedge clk); #1;

        // Reset in the 4th SHIFT cycle aborts the operation.
        d0 = done_cnt;
        a = 8'hFF; b = 8'hFF; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_sum",  64'(sum),  64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        run_op(8'h01, 8'h02, 1'b0);
        check("after_abort_sum", 64'(sum), 64'h03);

        // WIDTH=1 instance.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done1 && lat < 10);
        check("w1_latency", 64'(lat), 64'd2);
        check("w1_sum",  64'(sum1),  64'd1);
        check("w1_cout", 64'(cout1), 64'd1);
        @(posedge clk); #1;
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("w1_sum_b",  64'(sum1),  64'd0);
        check("w1_cout_b", 64'(cout1), 64'd1);

        // Random sweep against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom));
        end

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
